// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: walks the PC, issues one request at a time to
// instruction memory, holds the fetched word for the core until it is
// consumed, and follows redirects and flushes. A misaligned target parks the
// unit in HALT until a flush or reset.
module pc_fetch_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic            misaligned,
  output logic [XLEN-1:0] instret
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_VALID,
    S_DROP,
    S_HALT
  } state_t;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam logic [XLEN-1:0] ONE  = XLEN'(1);

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req;
  logic [XLEN-1:0] r_addr;
  logic            r_valid;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_misaligned;
  logic [XLEN-1:0] r_instret;

  logic [XLEN-1:0] w_pc_plus4;
  logic            w_flush_misaligned;
  logic            w_redirect_misaligned;
  logic            w_keep_outstanding;

  assign w_pc_plus4            = r_inst_pc + FOUR;
  assign w_flush_misaligned    = (flush_pc[1:0] != 2'b00);
  assign w_redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  // An un-acked request must stay on the bus; its data is thrown away in DROP.
  assign w_keep_outstanding    = (r_state == S_DROP) ||
                                 ((r_state == S_FETCH) && !imem_ack);

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = r_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign pc_plus4   = w_pc_plus4;
  assign misaligned = r_misaligned;
  assign instret    = r_instret;

  // Fetch state machine: flush overrides everything, then per-state behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_BOOT;
      r_pc         <= RESET_VECTOR;
      r_req        <= 1'b0;
      r_addr       <= RESET_VECTOR;
      r_valid      <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_misaligned <= 1'b0;
      r_instret    <= '0;
    end else if (flush) begin
      r_pc    <= flush_pc;
      r_valid <= 1'b0;
      if (w_flush_misaligned) begin
        r_state      <= S_HALT;
        r_req        <= 1'b0;
        r_misaligned <= 1'b1;
      end else if (w_keep_outstanding) begin
        r_state      <= S_DROP;
        r_req        <= 1'b1;
        r_misaligned <= 1'b0;
      end else begin
        r_state      <= S_FETCH;
        r_req        <= 1'b1;
        r_addr       <= flush_pc;
        r_misaligned <= 1'b0;
      end
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_inst    <= imem_rdata;
            r_inst_pc <= r_pc;
            r_valid   <= 1'b1;
            r_req     <= 1'b0;
            r_state   <= S_VALID;
          end
        end
        S_VALID: begin
          if (!stall) begin
            r_instret <= r_instret + ONE;
            r_valid   <= 1'b0;
            if (redirect && w_redirect_misaligned) begin
              r_misaligned <= 1'b1;
              r_state      <= S_HALT;
            end else if (redirect) begin
              r_pc    <= redirect_pc;
              r_addr  <= redirect_pc;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end else begin
              r_pc    <= w_pc_plus4;
              r_addr  <= w_pc_plus4;
              r_req   <= 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            r_addr  <= r_pc;
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a behavioural instruction memory with
// programmable ack delay, a queue of expected fetch addresses and a scoreboard
// of expected instructions that is popped whenever the core consumes one.
module tb_pc_fetch_unit;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sbEntry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        misaligned;
  logic [31:0] instret;

  int          checks = 0;
  int          failures = 0;
  int          ackDelay = 0;
  int          waitCnt = 0;
  bit          dropPending = 1'b0;
  bit          forceAck = 1'b0;
  logic [31:0] expInstret = '0;
  logic [31:0] expAddrQ[$];
  sbEntry_t    sbQ[$];

  pc_fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .pc_plus4    (pc_plus4),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .misaligned  (misaligned),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] memData(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  // One clock: drive inputs at negedge, answer memory, update the model,
  // then return just after the rising edge.
  task automatic applyStimulus(input bit s, input bit r, input logic [31:0] rpc,
                               input bit f, input logic [31:0] fpc);
    sbEntry_t    e;
    logic [31:0] ea;
    @(negedge clk);
    stall = s; redirect = r; redirect_pc = rpc; flush = f; flush_pc = fpc;
    imem_ack = 1'b0;
    imem_rdata = '0;
    if (forceAck) begin
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_DEAD;
    end else if (imem_req) begin
      if (waitCnt >= ackDelay) begin
        imem_ack = 1'b1;
        imem_rdata = memData(imem_addr);
        waitCnt = 0;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end
    if (rst_n) begin
      if (imem_ack && imem_req) begin
        if (f) begin
          // acked data is discarded by the flush
        end else if (dropPending) begin
          dropPending = 1'b0;
        end else begin
          checks++;
          if (expAddrQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL fetch_addr unexpected request actual=%h required=none", imem_addr);
          end else begin
            ea = expAddrQ.pop_front();
            if (imem_addr !== ea) begin
              failures++;
              $display("[TB] FAIL fetch_addr actual=%h required=%h", imem_addr, ea);
            end
            e.addr = ea;
            e.data = memData(ea);
            sbQ.push_back(e);
          end
        end
      end else if (imem_req && f) begin
        dropPending = 1'b1;
      end
      if (inst_valid && (f || !s)) begin
        checks++;
        if (sbQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL inst_valid unexpected actual_pc=%h required=none", inst_pc);
        end else begin
          e = sbQ.pop_front();
          if (!f) begin
            expInstret = expInstret + 32'd1;
            if (inst !== e.data || inst_pc !== e.addr) begin
              failures++;
              $display("[TB] FAIL consume actual=%h@%h required=%h@%h", inst, inst_pc, e.data, e.addr);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      checks++;
      if (instret !== expInstret) begin
        failures++;
        $display("[TB] FAIL instret actual=%h required=%h", instret, expInstret);
      end
    end
  endtask

  task automatic clearModel();
    expAddrQ.delete();
    sbQ.delete();
    dropPending = 1'b0;
    expInstret = '0;
    waitCnt = 0;
    ackDelay = 0;
    forceAck = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clearModel();
    applyStimulus(0, 0, '0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0);
    rst_n = 1'b1;
  endtask

  task automatic run_consumes(input int target, input int maxCycles);
    int n = 0;
    while (expInstret < 32'(target) && n < maxCycles) begin
      applyStimulus(0, 0, '0, 0, '0);
      n++;
    end
    checks++;
    if (expInstret < 32'(target)) begin
      failures++;
      $display("[TB] FAIL consume_timeout actual=%0d required=%0d", expInstret, target);
    end
  endtask

  task automatic wait_valid(input int maxCycles);
    int n = 0;
    while (!inst_valid && n < maxCycles) begin
      applyStimulus(1, 0, '0, 0, '0);
      n++;
    end
    checks++;
    if (!inst_valid) begin
      failures++;
      $display("[TB] FAIL valid_timeout actual=%b required=1", inst_valid);
    end
  endtask

  // Async reset during an outstanding request, with acks forced during reset.
  task automatic test_reset();
    do_reset();
    expAddrQ.push_back(32'h0);
    wait_valid(10);
    ackDelay = 5;
    expAddrQ.push_back(32'h4);
    applyStimulus(0, 0, '0, 0, '0);
    applyStimulus(1, 0, '0, 0, '0);
    applyStimulus(1, 0, '0, 0, '0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_req actual=%b/%h/%b required=0/00000000/0", imem_req, imem_addr, inst_valid);
    end
    checks++;
    if (inst !== 32'h0 || inst_pc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_inst actual=%h/%h required=0/0", inst, inst_pc);
    end
    checks++;
    if (misaligned !== 1'b0 || instret !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_misc actual=%b/%h required=0/0", misaligned, instret);
    end
    forceAck = 1'b1;
    applyStimulus(0, 0, '0, 0, '0);
    applyStimulus(0, 0, '0, 0, '0);
    clearModel();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL boot_idle actual=%b/%b required=0/0", imem_req, inst_valid);
    end
    ackDelay = 5;
    applyStimulus(1, 0, '0, 0, '0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL first_fetch actual=%b/%h/%b required=1/00000000/0", imem_req, imem_addr, inst_valid);
    end
  endtask

  // Straight-line fetch of 0x0, 0x4, 0x8 with single-cycle acks.
  task automatic test_sequential();
    do_reset();
    expAddrQ.push_back(32'h0);
    expAddrQ.push_back(32'h4);
    expAddrQ.push_back(32'h8);
    expAddrQ.push_back(32'hC);
    run_consumes(3, 40);
    checks++;
    if (instret !== 32'd3) begin
      failures++;
      $display("[TB] FAIL seq_instret actual=%h required=00000003", instret);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      failures++;
      $display("[TB] FAIL seq_next actual=%b/%h required=1/0000000c", imem_req, imem_addr);
    end
  endtask

  // Aligned redirect from 0x10 to 0x100.
  task automatic test_redirect();
    do_reset();
    expAddrQ.push_back(32'h0);
    expAddrQ.push_back(32'h4);
    expAddrQ.push_back(32'h8);
    expAddrQ.push_back(32'hC);
    expAddrQ.push_back(32'h10);
    run_consumes(4, 40);
    wait_valid(10);
    checks++;
    if (inst_pc !== 32'h10) begin
      failures++;
      $display("[TB] FAIL redir_src actual=%h required=00000010", inst_pc);
    end
    expAddrQ.push_back(32'h100);
    applyStimulus(0, 1, 32'h100, 0, '0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instret !== 32'd5) begin
      failures++;
      $display("[TB] FAIL redir_target actual=%b/%h/%h required=1/00000100/00000005", imem_req, imem_addr, instret);
    end
    wait_valid(10);
    run_consumes(6, 10);
  endtask

  // Misaligned redirect halts until a flush restarts at 0x200.
  task automatic test_misaligned();
    do_reset();
    expAddrQ.push_back(32'h0);
    wait_valid(10);
    applyStimulus(0, 1, 32'h102, 0, '0);
    checks++;
    if (misaligned !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0 || instret !== 32'd1) begin
      failures++;
      $display("[TB] FAIL halt_entry actual=%b/%b/%b/%h required=1/0/0/00000001", misaligned, imem_req, inst_valid, instret);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, '0, 0, '0);
      checks++;
      if (imem_req !== 1'b0 || misaligned !== 1'b1) begin
        failures++;
        $display("[TB] FAIL halt_hold actual=%b/%b required=0/1", imem_req, misaligned);
      end
    end
    expAddrQ.push_back(32'h200);
    applyStimulus(0, 0, '0, 1, 32'h200);
    checks++;
    if (misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("[TB] FAIL halt_exit actual=%b/%b/%h required=0/1/00000200", misaligned, imem_req, imem_addr);
    end
    wait_valid(10);
    run_consumes(2, 10);
  endtask

  // Stall holds the instruction while redirect toggles.
  task automatic test_stall();
    do_reset();
    expAddrQ.push_back(32'h0);
    wait_valid(10);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, bit'(i & 1), 32'h100, 0, '0);
      checks++;
      if (inst !== memData(32'h0) || inst_pc !== 32'h0 || instret !== 32'h0 ||
          imem_req !== 1'b0 || inst_valid !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold actual=%h/%h/%h/%b/%b required=%h/0/0/0/1",
                 inst, inst_pc, instret, imem_req, inst_valid, memData(32'h0));
      end
    end
    expAddrQ.push_back(32'h4);
    run_consumes(1, 5);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      failures++;
      $display("[TB] FAIL stall_release actual=%b/%h required=1/00000004", imem_req, imem_addr);
    end
    run_consumes(2, 10);
  endtask

  // Flush during a slow fetch of 0x8: request held, data dropped, restart 0x40.
  task automatic test_flush_drop();
    do_reset();
    expAddrQ.push_back(32'h0);
    expAddrQ.push_back(32'h4);
    run_consumes(2, 20);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      failures++;
      $display("[TB] FAIL drop_pre actual=%b/%h required=1/00000008", imem_req, imem_addr);
    end
    ackDelay = 3;
    expAddrQ.push_back(32'h40);
    applyStimulus(0, 0, '0, 1, 32'h40);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL drop_hold actual=%b/%h/%b required=1/00000008/0", imem_req, imem_addr, inst_valid);
      end
      applyStimulus(0, 0, '0, 0, '0);
    end
    ackDelay = 0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drop_restart actual=%b/%h/%b required=1/00000040/0", imem_req, imem_addr, inst_valid);
    end
    wait_valid(10);
    run_consumes(3, 10);
  endtask

  // Flush in VALID and flush coinciding with an ack in FETCH.
  task automatic test_flush_variants();
    do_reset();
    expAddrQ.push_back(32'h0);
    wait_valid(10);
    expAddrQ.push_back(32'h80);
    applyStimulus(0, 0, '0, 1, 32'h80);
    checks++;
    if (inst_valid !== 1'b0 || imem_addr !== 32'h80 || instret !== 32'h0) begin
      failures++;
      $display("[TB] FAIL flush_valid actual=%b/%h/%h required=0/00000080/0", inst_valid, imem_addr, instret);
    end
    applyStimulus(0, 0, '0, 1, 32'h20);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || inst_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_ack actual=%b/%h/%b required=1/00000020/0", imem_req, imem_addr, inst_valid);
    end
    expAddrQ.delete();
    expAddrQ.push_back(32'h20);
    wait_valid(10);
    run_consumes(1, 5);
  endtask

  // Consuming the last word of the address space wraps to 0x0.
  task automatic test_wrap();
    do_reset();
    expAddrQ.push_back(32'hFFFF_FFFC);
    applyStimulus(0, 0, '0, 1, 32'hFFFF_FFFC);
    wait_valid(10);
    checks++;
    if (pc_plus4 !== 32'h0 || inst_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("[TB] FAIL wrap_plus4 actual=%h/%h required=00000000/fffffffc", pc_plus4, inst_pc);
    end
    expAddrQ.push_back(32'h0);
    run_consumes(1, 5);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL wrap_fetch actual=%b/%h required=1/00000000", imem_req, imem_addr);
    end
    wait_valid(10);
    run_consumes(2, 5);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_misaligned();
    test_stall();
    test_flush_drop();
    test_flush_variants();
    test_wrap();
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
